multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Iterative multiply/divide unit with controller, used by the EX stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and sequences a 1-bit-per-cycle shift-add multiply or restoring divide.
- Owns the HI/LO architectural registers and serves MFHI/MFLO reads.
- Raises a pipeline stall while results are pending, so the writeback checker sees correct HI/LO-derived values.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- op_valid  input  1  EX presents a mult/div/move op this cycle
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; others ignored
- src_a  input  WIDTH  rs operand (multiplicand/dividend/move source)
- src_b  input  WIDTH  rt operand (multiplier/divisor)
- rd_req  input  1  EX is executing MFHI/MFLO
- rd_sel  input  1  0=LO, 1=HI
- rd_data  output  WIDTH  selected HI/LO; combinational
- busy  output  1  iterative operation in flight
- stall  output  1  freeze IF/ID/EX this cycle

Behaviour:
- States: IDLE, RUN, FIX.
- Reset: state=IDLE, HI=LO=0, counter=0, busy=0, stall=0, rd_data=0 (LO selected). rst mid-operation aborts the op with no HI/LO write.
- Op acceptance: an op is accepted only when state==IDLE and op_valid=1.
  - MTHI/MTLO: write src_a into HI/LO at the next edge. State stays IDLE; busy stays 0.
  - MULT/MULTU/DIV/DIVU: at the accepting edge, latch operands and go to RUN.
    - Signed ops (MULT/DIV) latch absolute values and record the result signs.
    - Counter is loaded with 0.
- RUN: one multdiv_iter step per cycle.
  - Exit to FIX when counter==WIDTH-1 at the edge.
  - Counter increments each RUN cycle. It does not wrap because it is bounded by WIDTH.
- FIX: apply signs, write HI/LO, return to IDLE.
  - MULT: negate the 64-bit product if operand signs differ. HI={product[63:32]}, LO={product[31:0]}.
  - DIV: quotient is negated if signs differ. Remainder takes the dividend sign. LO=quotient, HI=remainder.
  - Unsigned ops skip negation.
- Latency: accept at edge 0. busy=1 for WIDTH+1 cycles (RUN for WIDTH cycles, FIX for 1). New HI/LO are visible on rd_data the cycle after FIX, i.e. cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero, detected at accept, still runs the full latency: LO=all ones, HI=dividend (raw src_a).
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0. This falls out of the unsigned core plus sign fix; verify it explicitly.
- stall = busy & (op_valid | rd_req). Non-mult/div instructions flow freely while busy.
- Simultaneous events:
  - An op that arrives while busy is held by stall and accepted in the first IDLE cycle.
  - rd_req in the same cycle as an accepting MTHI/MTLO returns the old value (read-before-write).
  - In the first IDLE cycle after FIX, rd_req returns the new result with stall=0.
- op codes 6–7 with op_valid: ignored, no state change.

Decomposition:
- Package multdiv_pkg holds:
  - op encodings OP_MULT..OP_MTLO
  - state encodings S_IDLE/S_RUN/S_FIX
  - default WIDTH/CNT_W
  - DIV0 result constants
- Sub-module multdiv_iter: purely combinational single step.
  - Inputs: mode, 2*WIDTH accumulator, operand register.
  - Multiply: conditional add of multiplicand into upper half, then shift right.
  - Divide: shift left, trial subtract of divisor from upper half, set quotient bit if non-negative.
  - Output: next accumulator.
- Controller, counter, sign logic and HI/LO registers stay in multdiv_ctrl.

Test Plan:
- MULT src_a=5040, src_b=8 → busy for 33 cycles; at cycle 34 MFLO=0x00009D80, MFHI=0; stall high for MFLO issued at cycle 5 until cycle 34.
- DIV src_a=40320, src_b=2 → LO=0x00004EC0, HI=0. DIV src_a=-7, src_b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT 0xFFFFFFFF×0xFFFFFFFF → HI=0, LO=1.
- DIVU src_a=3665, src_b=0 → LO=0xFFFFFFFF, HI=3665. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then MFHI next cycle → 0x1234, stall=0, busy=0. DIV issued while busy → stall until idle, then accepted with the same latency.
- rst=1 at RUN cycle 10 of MULT 6×4 → next cycle IDLE, HI=LO=0, busy=0. A subsequent MULT 6×4 gives LO=0x18.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_pkg : shared encodings and defaults for the iterative mult/div unit |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    // Divide by zero: LO is filled with this bit, HI returns the dividend.
    localparam logic DIV0_LO_FILL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/multdiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_iter : one combinational shift-add multiply / restoring divide step |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  mode_e              mode,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
        div_shift = acc_in[2*WIDTH-1:WIDTH-1];
        // Partial remainder stays below 2*divisor, so a WIDTH-bit difference is exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_ge    = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= opnd);
        if (mode == MODE_MUL) begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end else if (div_ge) begin
            acc_out = {div_diff, acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {div_shift[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_ctrl : HI/LO owner and sequencer for iterative MULT/DIV ops         |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall
);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    mode_e              mode;
    logic               neg_lo;
    logic               neg_hi;
    logic               div0;

    logic               is_md;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    multdiv_iter #(.WIDTH(WIDTH)) u_iter (
        .mode    (mode),
        .acc_in  (acc),
        .opnd    (opnd),
        .acc_out (acc_step)
    );

    always_comb begin
        is_md     = (op[2] == 1'b0);
        is_signed = (op[2] == 1'b0) && (op[0] == 1'b0);
        abs_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        prod_fix  = neg_lo ? -acc : acc;
        quo_fix   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (op_valid && is_md) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_W'(WIDTH-1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        stall   = busy & (op_valid | rd_req);
        rd_data = rd_sel ? hi : lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode   <= MODE_MUL;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (is_md) begin
                            cnt    <= '0;
                            mode   <= op[1] ? MODE_DIV : MODE_MUL;
                            neg_lo <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_hi <= is_signed & src_a[WIDTH-1];
                            div0   <= op[1] & (src_b == '0);
                            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                            if (op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, abs_a};
                                opnd <= abs_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, abs_b};
                                opnd <= abs_a;
                            end
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (mode == MODE_MUL) begin
                        {hi, lo} <= prod_fix;
                    end else begin
                        // With a zero divisor the core leaves |dividend| as remainder; sign fix restores src_a.
                        lo <= div0 ? {WIDTH{DIV0_LO_FILL}} : quo_fix;
                        hi <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multdiv_ctrl : directed self-checking bench for multdiv_ctrl             |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         rd_req;
    logic         rd_sel;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         stall;

    int n_cmp = 0;
    int n_bad = 0;

    multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        step();
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h, expected 0", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h, expected 0", rd_data); end
        rd_req = 1'b0;
        rd_sel = 1'b0;
        step();
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        issue(o, a, b);
        wait_idle(n);
        n_cmp++;
        if (n != 33) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d, expected 33", name, n); end
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== exp_lo) begin n_bad++; $display("FAIL %s_lo: got %h, expected %h", name, rd_data, exp_lo); end
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL %s_stall: got %b, expected 0", name, stall); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== exp_hi) begin n_bad++; $display("FAIL %s_hi: got %h, expected %h", name, rd_data, exp_hi); end
        rd_req = 1'b0;
        rd_sel = 1'b0;
        step();
    endtask

    task automatic test_mult_stall();
        int n;
        issue(OP_MULT, 32'd5040, 32'd8);
        repeat (4) step();
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 50) begin
            n++;
            step();
        end
        n_cmp++;
        if (n != 29) begin n_bad++; $display("FAIL mfl_stall_cycles: got %0d, expected 29", n); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_idle_at_34: got %b, expected 0", busy); end
        n_cmp++;
        if (rd_data !== 32'h0000_9D80) begin n_bad++; $display("FAIL mult_lo: got %h, expected 00009d80", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL mult_hi: got %h, expected 0", rd_data); end
        rd_req = 1'b0;
        rd_sel = 1'b0;
        step();
    endtask

    task automatic test_move();
        issue(OP_MTHI, 32'h0000_CAFE, 32'h0);
        op_valid = 1'b1;
        op       = OP_MTHI;
        src_a    = 32'h0000_1234;
        rd_req   = 1'b1;
        rd_sel   = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0000_CAFE) begin n_bad++; $display("FAIL mthi_read_before_write: got %h, expected 0000cafe", rd_data); end
        step();
        op_valid = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi_mfhi: got %h, expected 00001234", rd_data); end
        n_cmp++;
        if (stall !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mthi_flags: got stall=%b busy=%b, expected 0 0", stall, busy); end
        rd_req = 1'b0;
        issue(OP_MTLO, 32'h0000_5678, 32'h0);
        issue(3'd6, 32'h0000_DEAD, 32'h0000_BEEF);
        issue(3'd7, 32'h0000_DEAD, 32'h0000_BEEF);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_op_busy: got %b, expected 0", busy); end
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0000_5678) begin n_bad++; $display("FAIL mtlo_after_bad_op: got %h, expected 00005678", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0000_1234) begin n_bad++; $display("FAIL hi_after_bad_op: got %h, expected 00001234", rd_data); end
        rd_req = 1'b0;
        rd_sel = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULT, 32'd3, 32'd7);
        repeat (2) step();
        op_valid = 1'b1;
        op       = OP_DIV;
        src_a    = 32'd100;
        src_b    = 32'd7;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 50) begin
            n++;
            step();
        end
        n_cmp++;
        if (n != 31) begin n_bad++; $display("FAIL b2b_stall_cycles: got %0d, expected 31", n); end
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd21) begin n_bad++; $display("FAIL b2b_mult_lo: got %h, expected 00000015", rd_data); end
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_stall: got %b, expected 0", stall); end
        rd_req = 1'b0;
        step();
        op_valid = 1'b0;
        wait_idle(n);
        n_cmp++;
        if (n != 33) begin n_bad++; $display("FAIL b2b_div_busy_cycles: got %0d, expected 33", n); end
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd14) begin n_bad++; $display("FAIL b2b_div_lo: got %h, expected 0000000e", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd2) begin n_bad++; $display("FAIL b2b_div_hi: got %h, expected 00000002", rd_data); end
        rd_req = 1'b0;
        rd_sel = 1'b0;
        step();
    endtask

    task automatic test_rst_abort();
        issue(OP_MULT, 32'd6, 32'd4);
        repeat (9) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b, expected 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b, expected 0", busy); end
        rd_sel = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL abort_lo: got %h, expected 0", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL abort_hi: got %h, expected 0", rd_data); end
        rd_sel = 1'b0;
        step();
        run_op("mult_6x4", OP_MULT, 32'd6, 32'd4, 32'h0, 32'h0000_0018);
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        src_a    = '0;
        src_b    = '0;
        rd_req   = 1'b0;
        rd_sel   = 1'b0;
        test_reset();
        test_mult_stall();
        run_op("div_40320_2",   OP_DIV,   32'd40320,     32'd2,         32'h0,         32'h0000_4EC0);
        run_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m1_m1",    OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_0001);
        run_op("divu_by_zero",  OP_DIVU,  32'd3665,      32'd0,         32'd3665,      32'hFFFF_FFFF);
        run_op("div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        test_move();
        test_back_to_back();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
